ap_ctrl_perf_monitor: RTL and testbench

Synthesizable, multi-channel performance monitor for `ap_ctrl_hs`-style handshakes (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`). It sits alongside the design-under-test, next to the simulation-only dataflow monitors, and generalises their per-module status tracking to `NUM_CH` channels. It supports pipelined modules with up to `DEPTH` transactions in flight. It accumulates per-channel transaction count, latency min/max/sum and start-interval min/max, and exposes them through a registered readout port.

---
 rtl/ap_ctrl_perf_monitor.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
//
// Multi-channel performance monitor for ap_ctrl_hs style handshakes. For each
// channel it timestamps accepted starts into a small FIFO. Each accepted done
// retires the oldest outstanding start. From these events it accumulates the
// transaction count, latency min/max/sum and start-interval min/max.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous active-high reset
//   enable       event sampling enable (timestamp counter always runs)
//   clear        synchronous clear of statistics, sticky flags and freeze
//   finish       level; sets the sticky freeze state
//   ap_start     per-channel start
//   ap_ready     per-channel ready
//   ap_done      per-channel done
//   ap_continue  per-channel continue
//   rd_ch        readout channel select
//   rd_sel       readout field select
//   rd_data      registered readout, zero-extended
//   frozen       registered freeze state
//   any_error    registered OR of all sticky overflow/underflow flags
module ap_ctrl_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 32,
    parameter int SUM_W  = 48
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic                                          clear,
    input  logic                                          finish,
    input  logic [NUM_CH-1:0]                             ap_start,
    input  logic [NUM_CH-1:0]                             ap_ready,
    input  logic [NUM_CH-1:0]                             ap_done,
    input  logic [NUM_CH-1:0]                             ap_continue,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [2:0]                                    rd_sel,
    output logic [SUM_W-1:0]                              rd_data,
    output logic                                          frozen,
    output logic                                          any_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_X = SUM_W + 1;

    logic [TS_W-1:0]  ts;
    logic             freeze;
    logic             active;

    logic [TS_W-1:0]  mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [CNT_W-1:0] occ [NUM_CH];

    logic [TS_W-1:0]  txn_count [NUM_CH];
    logic [TS_W-1:0]  lat_min [NUM_CH];
    logic [TS_W-1:0]  lat_max [NUM_CH];
    logic [SUM_W-1:0] lat_sum [NUM_CH];
    logic [TS_W-1:0]  ii_min [NUM_CH];
    logic [TS_W-1:0]  ii_max [NUM_CH];
    logic [TS_W-1:0]  last_start [NUM_CH];
    logic [NUM_CH-1:0] has_start;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] unf;

    logic [NUM_CH-1:0] start_ev;
    logic [NUM_CH-1:0] done_ev;
    logic [NUM_CH-1:0] is_empty;
    logic [NUM_CH-1:0] is_full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] lat_vld;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] unf_set;
    logic [NUM_CH-1:0] ovf_nxt;
    logic [NUM_CH-1:0] unf_nxt;
    logic [TS_W-1:0]  lat_val [NUM_CH];
    logic [TS_W-1:0]  ii_val [NUM_CH];
    logic [SUM_X-1:0] sum_ext [NUM_CH];
    logic [SUM_W-1:0] sum_nxt [NUM_CH];
    logic [SUM_W-1:0] rd_next;

    // finish gates events in the very cycle it is raised, not only once the
    // freeze flag has been registered.
    assign active   = enable & ~freeze & ~finish;
    assign start_ev = {NUM_CH{active}} & ap_start & ap_ready;
    assign done_ev  = {NUM_CH{active}} & ap_done & ap_continue;

    // Sticky flags are computed ahead of the register so any_error can be
    // registered from the same next-state and appear one cycle after the cause.
    assign ovf_nxt = clear ? '0 : (ovf | ovf_set);
    assign unf_nxt = clear ? '0 : (unf | unf_set);

    assign frozen = freeze;

    // Per-channel event decode. A done on an empty FIFO paired with a start is
    // a zero-latency bypass that leaves the FIFO untouched; a start paired with
    // a done on a full FIFO replaces the head slot, so occupancy holds.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            is_empty[c] = (occ[c] == '0);
            is_full[c]  = (occ[c] == CNT_W'(DEPTH));
            push[c]     = start_ev[c] & (done_ev[c] ? ~is_empty[c] : ~is_full[c]);
            pop[c]      = done_ev[c] & ~is_empty[c];
            lat_vld[c]  = done_ev[c] & (~is_empty[c] | start_ev[c]);
            ovf_set[c]  = start_ev[c] & ~done_ev[c] & is_full[c];
            unf_set[c]  = done_ev[c] & ~start_ev[c] & is_empty[c];
            lat_val[c]  = is_empty[c] ? '0 : (ts - mem[c][rd_ptr[c]]);
            ii_val[c]   = ts - last_start[c];
            sum_ext[c]  = {1'b0, lat_sum[c]} + SUM_X'(lat_val[c]);
            sum_nxt[c]  = sum_ext[c][SUM_W] ? '1 : sum_ext[c][SUM_W-1:0];
        end
    end

    // Free-running timestamp, wraps modulo 2^TS_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Timestamp storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= ts;
            end
        end
    end

    // FIFO pointers and occupancy. clear does not touch these so that
    // in-flight transactions still retire with their true latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                end
                if (push[c] && !pop[c]) begin
                    occ[c] <= occ[c] + CNT_W'(1);
                end else if (pop[c] && !push[c]) begin
                    occ[c] <= occ[c] - CNT_W'(1);
                end
            end
        end
    end

    // Statistics. clear wins over events of the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                txn_count[c]  <= '0;
                lat_min[c]    <= '1;
                lat_max[c]    <= '0;
                lat_sum[c]    <= '0;
                ii_min[c]     <= '1;
                ii_max[c]     <= '0;
                last_start[c] <= '0;
            end
            has_start <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                txn_count[c] <= '0;
                lat_min[c]   <= '1;
                lat_max[c]   <= '0;
                lat_sum[c]   <= '0;
                ii_min[c]    <= '1;
                ii_max[c]    <= '0;
            end
            has_start <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (lat_vld[c]) begin
                    if (txn_count[c] != '1) begin
                        txn_count[c] <= txn_count[c] + TS_W'(1);
                    end
                    if (lat_val[c] < lat_min[c]) begin
                        lat_min[c] <= lat_val[c];
                    end
                    if (lat_val[c] > lat_max[c]) begin
                        lat_max[c] <= lat_val[c];
                    end
                    lat_sum[c] <= sum_nxt[c];
                end
                if (start_ev[c]) begin
                    if (has_start[c]) begin
                        if (ii_val[c] < ii_min[c]) begin
                            ii_min[c] <= ii_val[c];
                        end
                        if (ii_val[c] > ii_max[c]) begin
                            ii_max[c] <= ii_val[c];
                        end
                    end
                    last_start[c] <= ts;
                    has_start[c]  <= 1'b1;
                end
            end
        end
    end

    // Sticky flags, freeze state and the error summary.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf       <= '0;
            unf       <= '0;
            freeze    <= 1'b0;
            any_error <= 1'b0;
        end else begin
            ovf       <= ovf_nxt;
            unf       <= unf_nxt;
            any_error <= |(ovf_nxt | unf_nxt);
            if (clear) begin
                freeze <= 1'b0;
            end else if (finish) begin
                freeze <= 1'b1;
            end
        end
    end

    // Readout field select; out-of-range channels read as zero.
    always_comb begin
        rd_next = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                3'd0:    rd_next = SUM_W'(txn_count[rd_ch]);
                3'd1:    rd_next = SUM_W'(lat_min[rd_ch]);
                3'd2:    rd_next = SUM_W'(lat_max[rd_ch]);
                3'd3:    rd_next = lat_sum[rd_ch];
                3'd4:    rd_next = SUM_W'(ii_min[rd_ch]);
                3'd5:    rd_next = SUM_W'(ii_max[rd_ch]);
                3'd6:    rd_next = SUM_W'(occ[rd_ch]);
                3'd7:    rd_next = SUM_W'({unf[rd_ch], ovf[rd_ch]});
                default: rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor
//
// Directed bench for ap_ctrl_perf_monitor. The bench runs with an 8-bit
// timestamp so that timestamp wrap is reachable quickly. The bench cycle
// counter cyc tracks the DUT timestamp. Every expected readout or flag value
// is queued with the cycle in which it must appear. A separate monitor
// compares the queued values on the falling edge.
module tb_ap_ctrl_perf_monitor;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 8;
    localparam int SUM_W  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear;
    logic              finish;
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic [1:0]        rd_ch;
    logic [2:0]        rd_sel;
    logic [SUM_W-1:0]  rd_data;
    logic              frozen;
    logic              any_error;

    // kind 0 = rd_data, 1 = frozen, 2 = any_error
    typedef struct {
        int          due;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t ent;
    int   cyc;
    int   vectors;
    int   miscompares;

    ap_ctrl_perf_monitor #(
        .NUM_CH(NUM_CH),
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .SUM_W (SUM_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .finish     (finish),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .rd_ch      (rd_ch),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .frozen     (frozen),
        .any_error  (any_error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops every expectation that has come due in this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            ent = sb.pop_front();
            case (ent.kind)
                0:       checkOutput(ent.name, rd_data, ent.exp);
                1:       checkOutput(ent.name, {15'd0, frozen}, ent.exp);
                default: checkOutput(ent.name, {15'd0, any_error}, ent.exp);
            endcase
        end
    end

    task automatic applyStimulus(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] dn,
                                 input logic fin, input logic clr);
        ap_start = st;
        ap_done  = dn;
        finish   = fin;
        clear    = clr;
        @(posedge clock);
        #1;
        cyc++;
        ap_start = '0;
        ap_done  = '0;
        finish   = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idleTo(input int target);
        while (cyc < target) applyStimulus('0, '0, 1'b0, 1'b0);
    endtask

    // Expect a flag value one cycle after the current one.
    task automatic expectFlag(input int kind, input logic [15:0] exp, input string name);
        sb.push_back('{cyc + 1, kind, exp, name});
    endtask

    // Issue one read in an otherwise idle cycle.
    task automatic readCheck(input logic [1:0] ch, input logic [2:0] sel,
                             input logic [15:0] exp, input string name);
        rd_ch  = ch;
        rd_sel = sel;
        sb.push_back('{cyc + 1, 0, exp, name});
        applyStimulus('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        clear       = 1'b0;
        finish      = 1'b0;
        ap_start    = '0;
        ap_done     = '0;
        ap_ready    = '1;
        ap_continue = '1;
        rd_ch       = '0;
        rd_sel      = '0;

        // Outputs while reset is held
        sb.push_back('{0, 0, 16'h0000, "rst_rd_data"});
        sb.push_back('{0, 1, 16'h0000, "rst_frozen"});
        sb.push_back('{0, 2, 16'h0000, "rst_any_error"});
        #12;
        reset = 1'b0;

        readCheck(2'd0, 3'd1, 16'h00FF, "rst_lat_min");
        readCheck(2'd0, 3'd0, 16'h0000, "rst_txn_count");
        readCheck(2'd1, 3'd4, 16'h00FF, "rst_ii_min");

        // Single transaction: start at 10, done at 17
        idleTo(10);
        applyStimulus(4'b0001, '0, 1'b0, 1'b0);
        idleTo(17);
        applyStimulus('0, 4'b0001, 1'b0, 1'b0);
        readCheck(2'd0, 3'd0, 16'd1,    "single_txn");
        readCheck(2'd0, 3'd1, 16'd7,    "single_lat_min");
        readCheck(2'd0, 3'd2, 16'd7,    "single_lat_max");
        readCheck(2'd0, 3'd3, 16'd7,    "single_lat_sum");
        readCheck(2'd0, 3'd4, 16'h00FF, "single_ii_min");
        readCheck(2'd0, 3'd6, 16'd0,    "single_occ");

        // Pipelined ch1: starts at 30,32,34, dones at 35,37,39
        idleTo(30);
        for (int t = 30; t < 40; t++) begin
            logic [NUM_CH-1:0] st;
            logic [NUM_CH-1:0] dn;
            st = (t == 30 || t == 32 || t == 34) ? 4'b0010 : 4'b0000;
            dn = (t == 35 || t == 37 || t == 39) ? 4'b0010 : 4'b0000;
            if (t == 35) begin
                rd_ch  = 2'd1;
                rd_sel = 3'd6;
                sb.push_back('{cyc + 1, 0, 16'd3, "pipe_occ_peak"});
            end
            applyStimulus(st, dn, 1'b0, 1'b0);
        end
        readCheck(2'd1, 3'd0, 16'd3,  "pipe_txn");
        readCheck(2'd1, 3'd1, 16'd5,  "pipe_lat_min");
        readCheck(2'd1, 3'd2, 16'd5,  "pipe_lat_max");
        readCheck(2'd1, 3'd3, 16'd15, "pipe_lat_sum");
        readCheck(2'd1, 3'd4, 16'd2,  "pipe_ii_min");
        readCheck(2'd1, 3'd5, 16'd2,  "pipe_ii_max");
        readCheck(2'd1, 3'd6, 16'd0,  "pipe_occ_end");

        // Overflow: five starts on ch2 at 50..54
        idleTo(50);
        for (int t = 50; t < 55; t++) begin
            if (t == 53) expectFlag(2, 16'd0, "ovf_err_before");
            if (t == 54) expectFlag(2, 16'd1, "ovf_err_next");
            applyStimulus(4'b0100, '0, 1'b0, 1'b0);
        end
        readCheck(2'd2, 3'd7, 16'd1, "ovf_flag");
        readCheck(2'd2, 3'd6, 16'd4, "ovf_occ");
        readCheck(2'd2, 3'd4, 16'd1, "ovf_ii_min");

        // Underflow: done on empty ch3 at 60
        idleTo(60);
        applyStimulus('0, 4'b1000, 1'b0, 1'b0);
        readCheck(2'd3, 3'd7, 16'd2, "unf_flag");
        readCheck(2'd3, 3'd0, 16'd0, "unf_txn");

        // Clear at 65: stats and flags reset, FIFOs kept
        idleTo(64);
        expectFlag(2, 16'd1, "err_before_clear");
        applyStimulus('0, '0, 1'b0, 1'b0);
        expectFlag(2, 16'd0, "err_after_clear");
        applyStimulus('0, '0, 1'b0, 1'b1);
        readCheck(2'd2, 3'd7, 16'd0, "clear_flags");
        readCheck(2'd2, 3'd6, 16'd4, "clear_occ_kept");
        readCheck(2'd0, 3'd0, 16'd0, "clear_txn");

        // Start+done on full ch2 at 70: pops the 50 entry
        idleTo(70);
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        readCheck(2'd2, 3'd6, 16'd4,    "full_sim_occ");
        readCheck(2'd2, 3'd7, 16'd0,    "full_sim_no_ovf");
        readCheck(2'd2, 3'd0, 16'd1,    "full_sim_txn");
        readCheck(2'd2, 3'd1, 16'd20,   "full_sim_lat");
        readCheck(2'd2, 3'd4, 16'h00FF, "full_sim_ii_min");

        // Start+done on empty ch3 at 80: bypass
        idleTo(80);
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
        readCheck(2'd3, 3'd0, 16'd1, "bypass_txn");
        readCheck(2'd3, 3'd1, 16'd0, "bypass_lat_min");
        readCheck(2'd3, 3'd2, 16'd0, "bypass_lat_max");
        readCheck(2'd3, 3'd6, 16'd0, "bypass_occ");
        readCheck(2'd3, 3'd7, 16'd0, "bypass_flags");

        // Timestamp wrap: start at ts 250, done at ts 4
        idleTo(250);
        applyStimulus(4'b0001, '0, 1'b0, 1'b0);
        idleTo(260);
        applyStimulus('0, 4'b0001, 1'b0, 1'b0);
        readCheck(2'd0, 3'd0, 16'd1,  "wrap_txn");
        readCheck(2'd0, 3'd1, 16'd10, "wrap_lat_min");
        readCheck(2'd0, 3'd2, 16'd10, "wrap_lat_max");
        readCheck(2'd0, 3'd3, 16'd10, "wrap_lat_sum");

        // Freeze mid-flight on ch1, then clear and let the done count
        idleTo(300);
        applyStimulus(4'b0010, '0, 1'b0, 1'b0);
        idleTo(302);
        expectFlag(1, 16'd0, "frozen_before");
        applyStimulus('0, '0, 1'b0, 1'b0);
        expectFlag(1, 16'd1, "frozen_set");
        applyStimulus('0, '0, 1'b1, 1'b0);
        idleTo(306);
        applyStimulus('0, 4'b0010, 1'b0, 1'b0);
        readCheck(2'd1, 3'd0, 16'd0, "frozen_txn_held");
        readCheck(2'd1, 3'd6, 16'd1, "frozen_occ_held");
        readCheck(2'd1, 3'd3, 16'd0, "frozen_sum_held");
        idleTo(310);
        expectFlag(1, 16'd0, "frozen_cleared");
        applyStimulus('0, '0, 1'b0, 1'b1);
        idleTo(315);
        applyStimulus('0, 4'b0010, 1'b0, 1'b0);
        readCheck(2'd1, 3'd0, 16'd1,  "thaw_txn");
        readCheck(2'd1, 3'd1, 16'd15, "thaw_lat_min");
        readCheck(2'd1, 3'd2, 16'd15, "thaw_lat_max");
        readCheck(2'd1, 3'd3, 16'd15, "thaw_lat_sum");
        readCheck(2'd1, 3'd6, 16'd0,  "thaw_occ");

        applyStimulus('0, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
            miscompares += sb.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
